// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with tkeep/tuser sideband, fill level and committed-packet count.
// Cut-through (PACKET_MODE=0) or store-and-forward (PACKET_MODE=1) with packet drop.
// Storage is a RAM with registered read (stage p1) followed by the output register (stage p2).
module axis_packet_fifo #(
  parameter int AXIS_BYTES  = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 1024,
  parameter int PACKET_MODE = 0
) (
  input  logic                        clk,
  input  logic                        sresetn,
  output logic                        axis_i_tready,
  input  logic                        axis_i_tvalid,
  input  logic                        axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]     axis_i_tdata,
  input  logic [AXIS_BYTES-1:0]       axis_i_tkeep,
  input  logic [USER_WIDTH-1:0]       axis_i_tuser,
  input  logic                        axis_i_tdrop,
  input  logic                        axis_o_tready,
  output logic                        axis_o_tvalid,
  output logic                        axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]     axis_o_tdata,
  output logic [AXIS_BYTES-1:0]       axis_o_tkeep,
  output logic [USER_WIDTH-1:0]       axis_o_tuser,
  output logic [$clog2(DEPTH):0]      level,
  output logic [$clog2(DEPTH):0]      pkt_count,
  output logic                        drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AXIS_BYTES * 8;
  localparam int EW = 1 + USER_WIDTH + AXIS_BYTES + DW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic {ST_ACCEPT, ST_DISCARD} state_t;

  state_t        state, state_next;
  logic [AW:0]   wp, cp, rp;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] ram_q_p1;
  logic          vld_p1;

  logic          acc, dlv, ld_out, rd_en, flag_drop, oversize, discard_exit;
  logic          commit, pkt_dec;
  logic [AW:0]   fill, limit, wp_inc, level_next;

  // Next-state decode: handshakes, read issue, drop/oversize detection and next level
  always_comb begin
    acc          = axis_i_tvalid && axis_i_tready && (state == ST_ACCEPT);
    dlv          = axis_o_tvalid && axis_o_tready;
    ld_out       = !axis_o_tvalid || axis_o_tready;
    // In packet mode the reader is fenced by the commit pointer
    limit        = (PACKET_MODE != 0) ? cp : wp;
    rd_en        = (rp != limit) && (!vld_p1 || ld_out);
    fill         = wp - cp;
    wp_inc       = wp + ONE;
    flag_drop    = (PACKET_MODE != 0) && acc && axis_i_tlast && axis_i_tdrop;
    commit       = (PACKET_MODE != 0) && acc && axis_i_tlast && !axis_i_tdrop;
    pkt_dec      = (PACKET_MODE != 0) && dlv && axis_o_tlast;
    // A packet that alone fills the FIFO can never be committed
    oversize     = (PACKET_MODE != 0) && (state == ST_ACCEPT) &&
                   (level == FULL) && (fill == FULL);
    discard_exit = (state == ST_DISCARD) && axis_i_tvalid && axis_i_tready && axis_i_tlast;
    // The dropped tlast beat is never counted; the partial packet is removed
    level_next   = level + {{AW{1'b0}}, (acc && !flag_drop)} - {{AW{1'b0}}, dlv};
    if (flag_drop || oversize) level_next = level_next - fill;
    state_next   = state;
    if (oversize)          state_next = ST_DISCARD;
    else if (discard_exit) state_next = ST_ACCEPT;
  end

  // Control state: FSM, pointers, counters, registered ready and pipeline valids
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state         <= ST_ACCEPT;
      wp            <= '0;
      cp            <= '0;
      rp            <= '0;
      level         <= '0;
      pkt_count     <= '0;
      drop_pulse    <= 1'b0;
      axis_i_tready <= 1'b0;
      vld_p1        <= 1'b0;
      axis_o_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      if (flag_drop || oversize) wp <= cp;
      else if (acc)              wp <= wp_inc;
      if (acc && ((PACKET_MODE == 0) || (axis_i_tlast && !axis_i_tdrop))) cp <= wp_inc;
      if (rd_en) rp <= rp + ONE;
      level         <= level_next;
      pkt_count     <= pkt_count + {{AW{1'b0}}, commit} - {{AW{1'b0}}, pkt_dec};
      drop_pulse    <= flag_drop || discard_exit;
      axis_i_tready <= (state_next == ST_DISCARD) || (level_next < FULL);
      if (rd_en)       vld_p1 <= 1'b1;
      else if (ld_out) vld_p1 <= 1'b0;
      if (ld_out) axis_o_tvalid <= vld_p1;
    end
  end

  // Stage p0 -> p1: RAM write port and registered read
  always_ff @(posedge clk) begin
    if (acc) mem[wp[AW-1:0]] <= {axis_i_tlast, axis_i_tuser, axis_i_tkeep, axis_i_tdata};
    if (rd_en) ram_q_p1 <= mem[rp[AW-1:0]];
  end

  // Stage p1 -> p2: output register, only reloaded when empty or being taken
  always_ff @(posedge clk) begin
    if (ld_out && vld_p1) {axis_o_tlast, axis_o_tuser, axis_o_tkeep, axis_o_tdata} <= ram_q_p1;
  end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Parametrised AXI-Stream FIFO. Successor to the basic single-mode stream FIFO.
- Adds tkeep/tuser sideband, a fill level output and a committed-packet count.
- Selectable cut-through or store-and-forward (packet) mode. In packet mode, flagged or oversized packets are dropped.
- Sits between MAC/parser stages and downstream consumers that must never see a partial or bad packet.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes; tkeep width equals AXIS_BYTES.
- USER_WIDTH, 1, tuser width, carried per beat.
- DEPTH, 1024, total beat capacity including the output register; power of 2, minimum 4.
- PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward.

Ports:
- clk  in  1  clock
- sresetn  in  1  synchronous active-low reset
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  end of packet
- axis_i_tdata  in  AXIS_BYTES*8  data
- axis_i_tkeep  in  AXIS_BYTES  byte enables
- axis_i_tuser  in  USER_WIDTH  sideband
- axis_i_tdrop  in  1  discard the packet; sampled only on the tlast beat; ignored when PACKET_MODE=0
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast / axis_o_tdata / axis_o_tkeep / axis_o_tuser  out  as input  delivered beat
- level  out  $clog2(DEPTH)+1  beats accepted and not yet delivered or dropped
- pkt_count  out  $clog2(DEPTH)+1  committed packets not yet fully delivered (PACKET_MODE=1; 0 otherwise)
- drop_pulse  out  1  one-cycle pulse per dropped packet

Behaviour:
- Reset: sresetn=0 synchronous, clk rising edge.
  - All pointers, counters, axis_o_tvalid, drop_pulse, level and pkt_count go to 0.
  - axis_i_tready goes 0 during reset and is 1 on the first cycle after reset.
  - Reset mid-packet discards all contents, including partial packets.
- Handshakes:
  - A beat transfers when tvalid && tready at a rising edge.
  - Output is AXIS-compliant: once axis_o_tvalid=1, tvalid and all payload are held stable until tready.
  - axis_i_tready = (level < DEPTH), registered; no combinational path from axis_o_tready.
- Storage: block RAM, registered read, plus one output register.
  - Write pointer wp, commit pointer cp, read pointer rp, each $clog2(DEPTH)+1 bits with wrap bit.
- Latency, cut-through: a beat accepted at edge N is presented with axis_o_tvalid=1 after edge N+2 when the FIFO was empty.
  - Steady throughput: 1 beat/cycle.
- Latency, packet mode: cp advances to wp at the tlast beat.
  - The first beat of that packet appears after edge T+2, where T is the tlast edge.
  - The reader never advances past cp.
- Drop via flag: tlast beat with axis_i_tdrop=1 sets wp back to cp.
  - level decreases by the packet's length; drop_pulse=1 next cycle; pkt_count unchanged.
- Oversize: packet mode, level==DEPTH, and no committed data remains ahead of the write packet.
  - The partial packet is discarded (wp=cp), and the block enters state DISCARD with tready forced 1.
  - All beats are swallowed up to and including tlast; then state returns to IDLE/ACCEPT.
  - drop_pulse fires once, on exit from DISCARD.
- Simultaneous read and write: level unchanged.
  - At level==DEPTH, tready=0 that cycle; a read frees space and tready=1 the following cycle.
- Simultaneous commit and last-beat read: pkt_count +1 and -1 net 0.
- Empty: tvalid=0, with no bubble beyond the stated latency.
- Wrap: the pointer MSB distinguishes full from empty. Wrap-around is transparent to the data sequence.
- PACKET_MODE=0: tdrop ignored, pkt_count=0, no DISCARD state, drop_pulse never asserted.

Test Plan:
- Cut-through, DEPTH=16, o_tready=1: 40 beats 0..39 streamed → output 0..39 in order; first tvalid 2 cycles after the first input; wrap passes cleanly.
- Backpressure: o_tready=0, write 16 beats → level=16, tready=0 on the cycle after the 16th; one read → tready=1 next cycle, level=15; tvalid/tdata stable throughout the stall.
- Packet mode: 5-beat packet, tkeep=0x1 and tuser=1 on the last beat → no tvalid until 2 cycles after tlast; beats delivered in order with tlast/tkeep/tuser intact; pkt_count 1→0 after the 5th read.
- Packet mode drop: 3-beat packet with tdrop=1 on the last beat, then a good 2-beat packet → only the 2-beat packet delivered; one drop_pulse; level returns to 0.
- Oversize: DEPTH=8, o_tready=0, 12-beat packet → the first 8 beats are accepted, then tready stays 1 through beat 12; nothing delivered; level=0; one drop_pulse; the next 4-beat packet is delivered intact.
- Reset mid-packet after 3 beats → level=0, tvalid=0; a subsequent packet is delivered without stale beats.
